// File: rtl/puf_pkg.sv
// puf_pkg: shared types and constants for the ring-oscillator PUF controller.
//   puf_state_t      controller state encoding
//   PUF_SYNC_CYCLES  counter-to-clk synchronizer latency (HOLD length)
//   PUF_NUM_OSC      oscillators in the bank (mux select range)
//   puf_sel()        modulo-PUF_NUM_OSC select arithmetic
package puf_pkg;

  localparam int PUF_SYNC_CYCLES = 2;
  localparam int PUF_NUM_OSC     = 32;
  localparam int PUF_SEL_W       = $clog2(PUF_NUM_OSC);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CLEAR,
    ST_SETTLE,
    ST_MEASURE,
    ST_HOLD,
    ST_COMPARE
  } puf_state_t;

  // Natural wrap of a PUF_SEL_W-bit add gives the modulo-32 select.
  function automatic logic [PUF_SEL_W-1:0] puf_sel(input logic [PUF_SEL_W-1:0] base,
                                                   input logic [PUF_SEL_W-1:0] off);
    return base + off;
  endfunction

endpackage

// File: rtl/puf_window_timer.sv
// puf_window_timer: loadable down-counter with zero flag.
//   clk, reset   clock, asynchronous active-high reset
//   load_i       load load_val_i (priority over counting)
//   load_val_i   value loaded; the phase lasts load_val_i+1 cycles
//   zero_o       count is zero (last cycle of the phase)
module puf_window_timer #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  output logic         zero_o
);

  logic [W-1:0] cnt_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)              cnt_q <= '0;
    else if (load_i)        cnt_q <= load_val_i;
    else if (cnt_q != '0)   cnt_q <= cnt_q - 1'b1;
  end

  assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/puf_eval_ctrl.sv
// puf_eval_ctrl: sequencing controller for the ring-oscillator PUF bank.
// For each of RESP_BITS oscillator pairs derived from a 5-bit challenge:
// clear counters, run oscillators to settle, gate a counting window, wait
// for the synchronizers, then compare counts into one response bit.
//   clk, reset          clock, asynchronous active-high reset
//   start, abort        request evaluation (IDLE only) / synchronous cancel
//   challenge           base challenge, latched on accepted start
//   osc_en              oscillator enable
//   sel_a, sel_b        mux selects for counter A / B
//   cnt_clr, cnt_gate   counter clear / counting window
//   cnt_a, cnt_b        synchronized counter values
//   busy, done          evaluation in progress / one-cycle completion pulse
//   response, sat       result word and saturation flag, held until next done
// All outputs are registered from the next-state decode.
module puf_eval_ctrl
  import puf_pkg::*;
#(
  parameter int WINDOW_CYCLES = 256,
  parameter int SETTLE_CYCLES = 4,
  parameter int CNT_W         = 16,
  parameter int RESP_BITS     = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic                 abort,
  input  logic [4:0]           challenge,
  output logic                 osc_en,
  output logic [4:0]           sel_a,
  output logic [4:0]           sel_b,
  output logic                 cnt_clr,
  output logic                 cnt_gate,
  input  logic [CNT_W-1:0]     cnt_a,
  input  logic [CNT_W-1:0]     cnt_b,
  output logic                 busy,
  output logic                 done,
  output logic [RESP_BITS-1:0] response,
  output logic                 sat
);

  localparam int KW      = (RESP_BITS > 1) ? $clog2(RESP_BITS) : 1;
  localparam int TMR_MAX = (WINDOW_CYCLES > SETTLE_CYCLES)
                         ? ((WINDOW_CYCLES > PUF_SYNC_CYCLES) ? WINDOW_CYCLES : PUF_SYNC_CYCLES)
                         : ((SETTLE_CYCLES > PUF_SYNC_CYCLES) ? SETTLE_CYCLES : PUF_SYNC_CYCLES);
  localparam int TMR_W   = (TMR_MAX > 1) ? $clog2(TMR_MAX) : 1;

  puf_state_t state_q, state_d;
  logic [KW-1:0]        k_q, k_d;
  logic [4:0]           ch_q, ch_d;
  logic [RESP_BITS-1:0] shreg_q, shreg_d;
  logic                 satacc_q, satacc_d;

  logic                 osc_en_q, cnt_gate_q, cnt_clr_q, busy_q, done_q, sat_q;
  logic [4:0]           sel_a_q, sel_b_q;
  logic [RESP_BITS-1:0] response_q;

  logic             tmr_ld, tmr_zero, fin, bit_k, sat_hit;
  logic [TMR_W-1:0] tmr_val;
  logic [4:0]       k2, sel_a_d, sel_b_d;

  // Shared phase timer; also reused to time HOLD so one counter covers
  // every multi-cycle state.
  puf_window_timer #(.W(TMR_W)) u_tmr (
    .clk        (clk),
    .reset      (reset),
    .load_i     (tmr_ld),
    .load_val_i (tmr_val),
    .zero_o     (tmr_zero)
  );

  assign bit_k   = (cnt_a > cnt_b);
  assign sat_hit = (cnt_a == '1) || (cnt_b == '1);

  always_comb begin
    state_d  = state_q;
    k_d      = k_q;
    ch_d     = ch_q;
    shreg_d  = shreg_q;
    satacc_d = satacc_q;
    tmr_ld   = 1'b0;
    tmr_val  = '0;
    fin      = 1'b0;
    unique case (state_q)
      ST_IDLE: if (start) begin
        ch_d     = challenge;
        k_d      = '0;
        shreg_d  = '0;
        satacc_d = 1'b0;
        state_d  = ST_CLEAR;
      end
      ST_CLEAR: begin
        tmr_ld  = 1'b1;
        tmr_val = TMR_W'(SETTLE_CYCLES - 1);
        state_d = ST_SETTLE;
      end
      ST_SETTLE: if (tmr_zero) begin
        tmr_ld  = 1'b1;
        tmr_val = TMR_W'(WINDOW_CYCLES - 1);
        state_d = ST_MEASURE;
      end
      ST_MEASURE: if (tmr_zero) begin
        tmr_ld  = 1'b1;
        tmr_val = TMR_W'(PUF_SYNC_CYCLES - 1);
        state_d = ST_HOLD;
      end
      ST_HOLD: if (tmr_zero) state_d = ST_COMPARE;
      ST_COMPARE: begin
        shreg_d[k_q] = bit_k;
        satacc_d     = satacc_q | sat_hit;
        if (k_q == KW'(RESP_BITS - 1)) begin
          fin     = 1'b1;
          state_d = ST_IDLE;
        end else begin
          k_d     = k_q + 1'b1;
          state_d = ST_CLEAR;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    // abort wins over everything, including the final COMPARE
    if (abort && state_q != ST_IDLE) begin
      state_d = ST_IDLE;
      fin     = 1'b0;
      tmr_ld  = 1'b0;
    end
  end

  // Selects follow the next pair index so they are valid on CLEAR entry.
  always_comb begin
    k2      = 5'({k_d, 1'b0});
    sel_a_d = puf_sel(ch_d, k2);
    sel_b_d = puf_sel(ch_d, k2 + 5'd1);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      k_q        <= '0;
      ch_q       <= '0;
      shreg_q    <= '0;
      satacc_q   <= 1'b0;
      osc_en_q   <= 1'b0;
      cnt_gate_q <= 1'b0;
      cnt_clr_q  <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      sat_q      <= 1'b0;
      sel_a_q    <= '0;
      sel_b_q    <= '0;
      response_q <= '0;
    end else begin
      state_q    <= state_d;
      k_q        <= k_d;
      ch_q       <= ch_d;
      shreg_q    <= shreg_d;
      satacc_q   <= satacc_d;
      osc_en_q   <= (state_d == ST_SETTLE) || (state_d == ST_MEASURE);
      cnt_gate_q <= (state_d == ST_MEASURE);
      cnt_clr_q  <= (state_d == ST_CLEAR);
      busy_q     <= (state_d != ST_IDLE);
      done_q     <= fin;
      if (state_d == ST_CLEAR) begin
        sel_a_q <= sel_a_d;
        sel_b_q <= sel_b_d;
      end
      if (fin) begin
        response_q <= shreg_d;
        sat_q      <= satacc_d;
      end
    end
  end

  assign osc_en   = osc_en_q;
  assign cnt_gate = cnt_gate_q;
  assign cnt_clr  = cnt_clr_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign sat      = sat_q;
  assign sel_a    = sel_a_q;
  assign sel_b    = sel_b_q;
  assign response = response_q;

endmodule

// File: tb/tb_puf_eval_ctrl.sv
// Directed bench for puf_eval_ctrl with W=8, S=2, RESP_BITS=4, CNT_W=8 (T=14).
module tb_puf_eval_ctrl;

  logic       clk = 1'b0;
  logic       reset, start, abort;
  logic [4:0] challenge;
  logic       osc_en, cnt_clr, cnt_gate, busy, done, sat;
  logic [4:0] sel_a, sel_b;
  logic [7:0] cnt_a, cnt_b;
  logic [3:0] response;

  int n_chk = 0;
  int n_err = 0;

  puf_eval_ctrl #(
    .WINDOW_CYCLES(8), .SETTLE_CYCLES(2), .CNT_W(8), .RESP_BITS(4)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .abort(abort), .challenge(challenge),
    .osc_en(osc_en), .sel_a(sel_a), .sel_b(sel_b), .cnt_clr(cnt_clr),
    .cnt_gate(cnt_gate), .cnt_a(cnt_a), .cnt_b(cnt_b), .busy(busy), .done(done),
    .response(response), .sat(sat)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Tables are packed per pair, pair 0 in the LSBs.
  task automatic run_eval(input logic [4:0] ch, input logic [31:0] a_tab, input logic [31:0] b_tab,
                          input logic [19:0] sa_tab, input logic [19:0] sb_tab,
                          input logic [3:0] exp_resp, input logic exp_sat,
                          input int abort_at, input bit hold_start);
    int c, p, gcnt, nclr;
    bit seen_done;
    @(negedge clk);
    challenge = ch;
    start     = 1'b1;
    @(posedge clk);
    c = 0; p = -1; gcnt = 0; nclr = 0; seen_done = 0;
    while (c < 120 && !seen_done) begin
      @(negedge clk);
      c++;
      if (!hold_start) start = 1'b0;
      if (c == 1) begin
        chk("busy_n1", busy, 1);
        chk("clr_n1", cnt_clr, 1);
      end
      if (cnt_clr) begin
        if (p >= 0 && abort_at == 0) chk("gate_len", gcnt, 8);
        p++; nclr++; gcnt = 0;
        if (p < 4) begin
          chk("sel_a", sel_a, sa_tab[p*5 +: 5]);
          chk("sel_b", sel_b, sb_tab[p*5 +: 5]);
          cnt_a = a_tab[p*8 +: 8];
          cnt_b = b_tab[p*8 +: 8];
        end
      end
      if (cnt_gate) gcnt++;
      if (abort_at != 0) begin
        if (c == abort_at) abort = 1'b1;
        if (c == abort_at + 1) begin
          abort = 1'b0;
          chk("abort_osc", osc_en, 0);
          chk("abort_gate", cnt_gate, 0);
          chk("abort_busy", busy, 0);
        end
      end
      if (done) begin
        seen_done = 1;
        chk("done_lat", c - 1, 56);
        chk("busy_at_done", busy, 0);
        chk("gate_len_last", gcnt, 8);
        chk("n_pairs", nclr, 4);
        chk("response", response, exp_resp);
        chk("sat", sat, exp_sat);
      end
    end
    if (abort_at != 0) begin
      chk("no_done", seen_done, 0);
      chk("resp_held", response, exp_resp);
      chk("sat_held", sat, exp_sat);
    end else begin
      chk("done_seen", seen_done, 1);
    end
    if (hold_start && seen_done) begin
      // IDLE is visited once, then the held start is taken
      @(negedge clk);
      chk("restart_clr", cnt_clr, 1);
      chk("restart_busy", busy, 1);
      start = 1'b0;
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      chk("abort_clear", busy, 0);
    end
  endtask

  initial begin
    int bcnt;
    reset = 1'b1; start = 1'b0; abort = 1'b0; challenge = '0;
    cnt_a = '0; cnt_b = '0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    chk("rst_osc", osc_en, 0);
    chk("rst_gate", cnt_gate, 0);
    chk("rst_clr", cnt_clr, 0);
    chk("rst_done", done, 0);
    chk("rst_sel", {sel_a, sel_b}, 0);
    chk("rst_resp", {sat, response}, 0);
    bcnt = 0;
    repeat (100) begin
      @(negedge clk);
      if (busy || osc_en || done) bcnt++;
    end
    chk("idle_100", bcnt, 0);

    // all pairs a>b
    run_eval(5'd3, {8'd20, 8'd20, 8'd20, 8'd20}, {8'd10, 8'd10, 8'd10, 8'd10},
             {5'd9, 5'd7, 5'd5, 5'd3}, {5'd10, 5'd8, 5'd6, 5'd4}, 4'b1111, 1'b0, 0, 0);
    // wrap-around selects, ties give 0
    run_eval(5'd30, {8'd7, 8'd7, 8'd7, 8'd7}, {8'd7, 8'd7, 8'd7, 8'd7},
             {5'd4, 5'd2, 5'd0, 5'd30}, {5'd5, 5'd3, 5'd1, 5'd31}, 4'b0000, 1'b0, 0, 0);
    // saturation on pair 2, mixed bits: 5>6=0, 9>3=1, 255>100=1, 1>1=0
    run_eval(5'd0, {8'd1, 8'd255, 8'd9, 8'd5}, {8'd1, 8'd100, 8'd3, 8'd6},
             {5'd6, 5'd4, 5'd2, 5'd0}, {5'd7, 5'd5, 5'd3, 5'd1}, 4'b0110, 1'b1, 0, 0);
    // abort in MEASURE of pair 1 (MEASURE covers cycles 18..25)
    run_eval(5'd10, {8'd0, 8'd0, 8'd90, 8'd90}, {8'd0, 8'd0, 8'd1, 8'd1},
             {5'd16, 5'd14, 5'd12, 5'd10}, {5'd17, 5'd15, 5'd13, 5'd11}, 4'b0110, 1'b1, 20, 0);
    // full run after abort, start held high throughout; bits 1,0,0,1; sat clears
    run_eval(5'd31, {8'd200, 8'd0, 8'd50, 8'd1}, {8'd199, 8'd0, 8'd60, 8'd0},
             {5'd5, 5'd3, 5'd1, 5'd31}, {5'd6, 5'd4, 5'd2, 5'd0}, 4'b1001, 1'b0, 0, 1);

    // reset during HOLD of pair 0 (cycles 12..13)
    @(negedge clk);
    challenge = 5'd5;
    start     = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (11) @(negedge clk);
    chk("hold_busy", busy, 1);
    chk("hold_osc", osc_en, 0);
    chk("hold_sel", sel_a, 5);
    #2 reset = 1'b1;
    #1;
    chk("arst_busy", busy, 0);
    chk("arst_out", {osc_en, cnt_gate, cnt_clr, done, sat}, 0);
    chk("arst_sel", {sel_a, sel_b}, 0);
    chk("arst_resp", response, 0);
    @(negedge clk);
    reset = 1'b0;
    repeat (3) @(negedge clk);
    chk("post_rst_idle", busy, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/puf_eval_ctrl.md
# puf_eval_ctrl

Sequencing controller for the ring-oscillator PUF bank. On a start request, it expands a 5-bit challenge into RESP_BITS oscillator pairs and, for each pair, clears the two edge counters, enables the oscillators, and gates counting for a fixed window of system clocks. It then compares the two counts and accumulates the resulting bits into a response word. It sits between the host interface and the oscillator/mux/counter datapath, and is the only block that drives oscillator enable, mux selects and counter control.

## Interface
- WINDOW_CYCLES, 256: system clocks per counting window (≥1)
- SETTLE_CYCLES, 4: clocks oscillators run before gating opens (≥1)
- CNT_W, 16: counter width of cnt_a/cnt_b
- RESP_BITS, 8: response bits per evaluation (1..16)

- clk  in  1  system clock
- reset  in  1  asynchronous, active-high
- start  in  1  request evaluation; sampled only in IDLE
- abort  in  1  synchronous cancel; returns to IDLE, no done
- challenge  in  5  base challenge, latched on accepted start
- osc_en  out  1  oscillator bank enable
- sel_a, sel_b  out  5 each  mux selects for counter A / counter B
- cnt_clr  out  1  synchronous clear to both counters
- cnt_gate  out  1  counting window enable
- cnt_a, cnt_b  in  CNT_W each  counter values, synchronized to clk
- busy  out  1  high from the cycle after accepted start until done/abort
- done  out  1  one-cycle pulse, evaluation complete
- response  out  RESP_BITS  result word, held until next done
- sat  out  1  any count in this evaluation reached all-ones; held with response

## Operation
- States: IDLE, CLEAR, SETTLE, MEASURE, HOLD, COMPARE.
- IDLE: start=1 latches challenge, clears bit index k and the shift register, and goes to CLEAR. start is ignored in all other states.
- CLEAR (1 cycle): cnt_clr=1. sel_a=(challenge+2k) mod 32, sel_b=(challenge+2k+1) mod 32; wrap-around is modulo 32. Selects stay stable from CLEAR through COMPARE.
- SETTLE (SETTLE_CYCLES): osc_en=1, cnt_gate=0.
- MEASURE (WINDOW_CYCLES): osc_en=1, cnt_gate=1.
- HOLD (2 cycles, synchronizer latency): osc_en=0, cnt_gate=0.
- COMPARE (1 cycle): bit_k = (cnt_a > cnt_b). A tie gives 0. Either count equal to 2^CNT_W−1 sets the sticky sat flag for this evaluation. If k==RESP_BITS−1, go to IDLE: response←accumulated bits, sat output updated, done=1. Otherwise increment k and go to CLEAR.
- Bit order: response[k] = bit from pair k (LSB = first pair).
- abort=1 in any non-IDLE state: next state IDLE, osc_en/cnt_gate/cnt_clr low next cycle, no done. response and sat keep their previous values. abort has priority over COMPARE completion.
- A window/settle down-counter is shared across SETTLE and MEASURE and reloaded on each entry.

## Timing
- Reset: state IDLE; osc_en, cnt_gate, cnt_clr, busy, done, sat = 0; sel_a = sel_b = 0; response = 0.
- All outputs are registered.
- Start accepted at edge N: busy=1 and cnt_clr=1 during cycle N+1.
- Per-bit latency: T = 1 + SETTLE_CYCLES + WINDOW_CYCLES + 2 + 1. Defaults give 264.
- done asserts RESP_BITS·T cycles after the start edge (defaults: 2112). busy falls in the same cycle done pulses.
- start held high during done: a new evaluation is accepted one cycle after done, because IDLE is visited for one cycle.
- Reset mid-evaluation: immediate return to reset values. The partial response is discarded.

## Structure
- Shared package puf_pkg: state enum puf_state_t, constant PUF_SYNC_CYCLES=2, constant PUF_NUM_OSC=32.
- One sub-module: puf_window_timer (loadable down-counter with zero flag). It is used for SETTLE and MEASURE.
- Select arithmetic and the comparator stay in the top controller.

## Test plan
(Sim params: WINDOW_CYCLES=8, SETTLE_CYCLES=2, RESP_BITS=4, CNT_W=8, so T=14.)
- Reset release, no start -> all outputs 0, busy stays 0 for 100 cycles.
- challenge=5'd3, model cnt_a=20, cnt_b=10 every pair -> sel pairs (3,4),(5,6),(7,8),(9,10); response=4'b1111; done at start+56; sat=0.
- challenge=5'd30 -> sel pairs (30,31),(0,1),(2,3),(4,5) (wrap); ties cnt_a=cnt_b=7 give response=4'b0000.
- cnt_a=255 on pair 2 only -> sat=1 after done; response[2]=1.
- abort during MEASURE of pair 1 -> osc_en=0 next cycle, no done; previous response held. A new start then runs a full 56 cycles.
- Reset asserted mid-HOLD -> outputs return to reset values asynchronously; start pulses during busy are ignored; cnt_gate is high for exactly 8 cycles per pair.
